regfile_write_buffer: RTL and testbench

Write-side companion to the register file. It accepts register write requests through a valid/ready handshake and buffers them in a small in-order queue. It drains at most one entry per cycle into the register file's single write port (write enable, index, data). It also gives the read side a lookup of the youngest pending write for two read indices, so consumers can forward data that has not yet been committed.

---
 rtl/regfile_write_buffer.sv | 112 +++++++++++
 tb/tb_regfile_write_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// Purpose : in-order write queue in front of the register file's single write port,
//           with youngest-pending-write lookup for two read indices (forwarding).
// Latency : accepted request reaches rf_w_o one cycle later when the queue is empty and unstalled.
// Backpressure: wr_ready_o drops when all depth entries are occupied; rf_stall_i holds the drain.
// Ports   : clk_i/rst_i (sync, active-high); wr_valid_i/wr_ready_o/wr_idx_i/wr_data_i request side;
//           rf_stall_i/rf_w_o/rf_idx_o/rf_d_o register-file write port; q_idx*_i/q_hit*_o/q_d*_o
//           lookup ports; count_o/empty_o occupancy.
module regfile_write_buffer #(
  parameter int nregs = 8,
  parameter int rsize = 32,
  parameter int depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [$clog2(nregs)-1:0]   wr_idx_i,
  input  logic [rsize-1:0]           wr_data_i,
  input  logic                       rf_stall_i,
  output logic                       rf_w_o,
  output logic [$clog2(nregs)-1:0]   rf_idx_o,
  output logic [rsize-1:0]           rf_d_o,
  input  logic [$clog2(nregs)-1:0]   q_idx1_i,
  input  logic [$clog2(nregs)-1:0]   q_idx2_i,
  output logic                       q_hit1_o,
  output logic                       q_hit2_o,
  output logic [rsize-1:0]           q_d1_o,
  output logic [rsize-1:0]           q_d2_o,
  output logic [$clog2(depth+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int IW = $clog2(nregs);
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [IW-1:0]    ent_idx [depth];
  logic [rsize-1:0] ent_d   [depth];
  logic [depth-1:0] ent_vld;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;
  logic [PW-1:0]    slot;

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign wr_ready_o = !rst_i && (count_q < FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rf_w_o     = !rst_i && !empty_o && !rf_stall_i;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rf_w_o;
  assign rf_idx_o   = (rst_i || empty_o) ? '0 : ent_idx[head_q];
  assign rf_d_o     = (rst_i || empty_o) ? '0 : ent_d[head_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ent_vld <= '0;
    end else begin
      // push and pop never target the same slot: that needs full or empty,
      // and either condition blocks one of them.
      if (push) begin
        ent_vld[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop) begin
        ent_vld[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by ent_vld.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ent_idx[tail_q] <= wr_idx_i;
      ent_d[tail_q]   <= wr_data_i;
    end
  end

  // Walk from oldest (head) to youngest so a later match overrides an earlier
  // one; the head being drained this cycle still hits since the RF updates at the edge.
  always_comb begin
    q_hit1_o = 1'b0;
    q_hit2_o = 1'b0;
    q_d1_o   = '0;
    q_d2_o   = '0;
    slot     = '0;
    for (int i = 0; i < depth; i++) begin
      slot = head_q + PW'(i);
      if (!rst_i && ent_vld[slot] && (ent_idx[slot] == q_idx1_i)) begin
        q_hit1_o = 1'b1;
        q_d1_o   = ent_d[slot];
      end
      if (!rst_i && ent_vld[slot] && (ent_idx[slot] == q_idx2_i)) begin
        q_hit2_o = 1'b1;
        q_d2_o   = ent_d[slot];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Purpose : directed scoreboard bench for regfile_write_buffer.
// Latency : expected RF writes queued at issue, popped by a monitor on each rf_w_o.
// Backpressure: driven through rf_stall_i; acceptance expectations are hand-derived.
module tb_regfile_write_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [2:0]  wr_idx_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        rf_stall_i = 1'b0;
  logic        rf_w_o;
  logic [2:0]  rf_idx_o;
  logic [31:0] rf_d_o;
  logic [2:0]  q_idx1_i = '0;
  logic [2:0]  q_idx2_i = '0;
  logic        q_hit1_o;
  logic        q_hit2_o;
  logic [31:0] q_d1_o;
  logic [31:0] q_d2_o;
  logic [2:0]  count_o;
  logic        empty_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  regfile_write_buffer #(.nregs(8), .rsize(32), .depth(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_idx_i   (wr_idx_i),
    .wr_data_i  (wr_data_i),
    .rf_stall_i (rf_stall_i),
    .rf_w_o     (rf_w_o),
    .rf_idx_o   (rf_idx_o),
    .rf_d_o     (rf_d_o),
    .q_idx1_i   (q_idx1_i),
    .q_idx2_i   (q_idx2_i),
    .q_hit1_o   (q_hit1_o),
    .q_hit2_o   (q_hit2_o),
    .q_d1_o     (q_d1_o),
    .q_d2_o     (q_d2_o),
    .count_o    (count_o),
    .empty_o    (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every write pulse must match the oldest outstanding expected write.
  always @(negedge clk_i) begin
    if (rf_w_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected actual=idx %0h data %0h required=no write", rf_idx_o, rf_d_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_idx_o !== e.idx || rf_d_o !== e.d) begin
          errors++;
          $display("FAIL rf_write actual=idx %0h data %0h required=idx %0h data %0h",
                   rf_idx_o, rf_d_o, e.idx, e.d);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_push(input logic [2:0] idx, input logic [31:0] d, input bit expect_accept);
    wr_t e;
    wr_valid_i = 1'b1;
    wr_idx_i   = idx;
    wr_data_i  = d;
    e.idx = idx;
    e.d   = d;
    if (expect_accept) exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      cyc();
      n++;
    end
    chk("drain_timeout_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset: outputs forced quiet while rst_i is high.
    repeat (2) cyc();
    @(negedge clk_i);
    chk("rst_ready", 32'(wr_ready_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_rf_w", 32'(rf_w_o), 32'd0);
    chk("rst_rf_d", rf_d_o, 32'd0);
    cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ready", 32'(wr_ready_o), 32'd1);
    chk("idle_empty", 32'(empty_o), 32'd1);
    chk("idle_count", 32'(count_o), 32'd0);
    chk("idle_hit1", 32'(q_hit1_o), 32'd0);
    chk("idle_d1", q_d1_o, 32'd0);
    chk("idle_hit2", 32'(q_hit2_o), 32'd0);

    // Single write, one-cycle latency, head still forwards while draining.
    cyc();
    drive_push(3'd3, 32'hDEADBEEF, 1'b1);
    @(negedge clk_i);
    chk("single_ready", 32'(wr_ready_o), 32'd1);
    chk("single_no_bypass", 32'(rf_w_o), 32'd0);
    cyc();
    wr_valid_i = 1'b0;
    q_idx1_i   = 3'd3;
    @(negedge clk_i);
    chk("single_rf_w", 32'(rf_w_o), 32'd1);
    chk("single_hit1", 32'(q_hit1_o), 32'd1);
    chk("single_d1", q_d1_o, 32'hDEADBEEF);
    cyc();
    @(negedge clk_i);
    chk("single_empty_after", 32'(empty_o), 32'd1);
    chk("single_miss_after", 32'(q_hit1_o), 32'd0);
    chk("single_d1_after", q_d1_o, 32'd0);

    // Fill while stalled; a fifth request must be refused.
    rf_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive_push(3'(i), 32'h10 + 32'(i), 1'b1);
      @(negedge clk_i);
      chk("fill_ready", 32'(wr_ready_o), 32'd1);
      chk("fill_count", 32'(count_o), 32'(i));
    end
    cyc();
    drive_push(3'd4, 32'h99, 1'b0);
    @(negedge clk_i);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(wr_ready_o), 32'd0);
    chk("full_rf_w_stalled", 32'(rf_w_o), 32'd0);
    cyc();
    wr_valid_i = 1'b0;
    q_idx1_i   = 3'd2;
    q_idx2_i   = 3'd7;
    rf_stall_i = 1'b0;
    @(negedge clk_i);
    chk("full_lookup_hit1", 32'(q_hit1_o), 32'd1);
    chk("full_lookup_d1", q_d1_o, 32'h12);
    chk("full_lookup_hit2", 32'(q_hit2_o), 32'd0);
    chk("full_lookup_d2", q_d2_o, 32'd0);
    chk("drain_count_0", 32'(count_o), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      @(negedge clk_i);
      chk("drain_count", 32'(count_o), 32'(4 - i));
      chk("drain_ready", 32'(wr_ready_o), 32'd1);
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    wait_drain(4);

    // Duplicate index: youngest wins on lookup, oldest drains first.
    rf_stall_i = 1'b1;
    cyc();
    drive_push(3'd5, 32'hA, 1'b1);
    cyc();
    drive_push(3'd5, 32'hB, 1'b1);
    cyc();
    wr_valid_i = 1'b0;
    q_idx1_i   = 3'd5;
    q_idx2_i   = 3'd5;
    @(negedge clk_i);
    chk("dup_count", 32'(count_o), 32'd2);
    chk("dup_hit1", 32'(q_hit1_o), 32'd1);
    chk("dup_d1", q_d1_o, 32'hB);
    chk("dup_hit2", 32'(q_hit2_o), 32'd1);
    chk("dup_d2", q_d2_o, 32'hB);
    cyc();
    rf_stall_i = 1'b0;
    wait_drain(6);

    // Streaming across pointer wraparound: occupancy holds at one.
    for (int k = 0; k < 8; k++) begin
      cyc();
      drive_push(3'(k), 32'(k), 1'b1);
      @(negedge clk_i);
      chk("stream_ready", 32'(wr_ready_o), 32'd1);
      if (k > 0) chk("stream_count", 32'(count_o), 32'd1);
    end
    cyc();
    wr_valid_i = 1'b0;
    wait_drain(4);

    // Reset with pending entries discards them.
    rf_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive_push(3'(i + 1), 32'h100 + 32'(i), 1'b0);
    end
    cyc();
    wr_valid_i = 1'b0;
    q_idx1_i   = 3'd1;
    @(negedge clk_i);
    chk("mid_pending_count", 32'(count_o), 32'd3);
    cyc();
    rst_i      = 1'b1;
    rf_stall_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    chk("mid_rst_rf_w", 32'(rf_w_o), 32'd0);
    chk("mid_rst_hit1", 32'(q_hit1_o), 32'd0);
    cyc();
    @(negedge clk_i);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_empty", 32'(empty_o), 32'd1);
    chk("mid_rst_ready", 32'(wr_ready_o), 32'd0);
    cyc();
    rst_i = 1'b0;
    repeat (5) cyc();
    @(negedge clk_i);
    chk("post_rst_empty", 32'(empty_o), 32'd1);
    chk("post_rst_hit1", 32'(q_hit1_o), 32'd0);
    chk("post_rst_ready", 32'(wr_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
